// File: rtl/bird_motion_if.sv
// Frame/flap inputs and motion outputs exchanged between the game glue and
// the bird motion engine.
interface bird_motion_if;
  logic       vsync;
  logic       flap;
  logic [9:0] y;
  logic       frame_tick;
  logic       playing;
  logic       dead;

  modport master (output vsync, flap, input y, frame_tick, playing, dead);
  modport slave  (input vsync, flap, output y, frame_tick, playing, dead);
endinterface

// File: rtl/bird_motion.sv
// Per-frame vertical motion engine: gravity, flap impulse, terminal velocity,
// ceiling clamp and ground collision, stepped once per vsync falling edge.
module bird_motion #(
  parameter int Y_START      = 240,
  parameter int Y_MAX        = 465,
  parameter int GRAVITY      = 1,
  parameter int FLAP_IMPULSE = 8,
  parameter int VEL_MAX      = 10
) (
  input logic         dclk,
  input logic         clr,
  bird_motion_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLY, DEAD} state_t;

  localparam logic        [9:0]  YSTART10 = 10'(Y_START);
  localparam logic        [9:0]  YMAX10   = 10'(Y_MAX);
  localparam logic signed [10:0] YMAX11   = 11'(Y_MAX);
  localparam logic signed [8:0]  GRAV9    = 9'(GRAVITY);
  localparam logic signed [8:0]  VMAX9    = 9'(VEL_MAX);
  localparam logic signed [7:0]  VMAX8    = 8'(VEL_MAX);
  localparam logic signed [7:0]  VFLAP    = 8'(-FLAP_IMPULSE);

  state_t             state, state_n;
  logic [2:0]         fsync;      // [0],[1] synchronizer, [2] previous sample
  logic               flap_edge;
  logic               pending;
  logic               vs_d;
  logic               tick;
  logic               playing_q, dead_q;
  logic [9:0]         y_q, y_n;
  logic signed [7:0]  vel, vel_n;
  logic signed [8:0]  vinc;
  logic signed [7:0]  vnew;
  logic signed [10:0] yn;

  assign flap_edge = fsync[1] & ~fsync[2];

  // Bring the button into the pixel domain and keep one extra stage for edge detect
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) fsync <= '0;
    else     fsync <= {fsync[1:0], bus.flap};
  end

  // Latch a flap until the frame step; a fresh edge wins over the consume
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) pending <= 1'b0;
    else     pending <= flap_edge | (pending & ~tick);
  end

  // One-cycle frame tick on the vsync 1->0 transition
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      vs_d <= 1'b1;
      tick <= 1'b0;
    end else begin
      vs_d <= bus.vsync;
      tick <= vs_d & ~bus.vsync;
    end
  end

  // Next-state, velocity and position; only the tick cycle moves anything
  always_comb begin
    state_n = state;
    y_n     = y_q;
    vel_n   = vel;
    vinc    = {vel[7], vel} + GRAV9;
    if (pending)           vnew = VFLAP;
    else if (vinc > VMAX9) vnew = VMAX8;
    else                   vnew = vinc[7:0];
    yn = $signed({1'b0, y_q}) + $signed({{3{vnew[7]}}, vnew});
    if (tick) begin
      case (state)
        IDLE: begin
          if (pending) begin
            state_n = FLY;
            vel_n   = vnew;
            y_n     = yn[9:0];
          end else begin
            y_n   = YSTART10;
            vel_n = '0;
          end
        end
        FLY: begin
          if (yn < 11'sd0) begin
            y_n   = '0;
            vel_n = '0;
          end else if (yn >= YMAX11) begin
            y_n     = YMAX10;
            vel_n   = '0;
            state_n = DEAD;
          end else begin
            y_n   = yn[9:0];
            vel_n = vnew;
          end
        end
        DEAD: begin
          if (pending) begin
            state_n = IDLE;
            y_n     = YSTART10;
            vel_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          y_n     = YSTART10;
          vel_n   = '0;
        end
      endcase
    end
  end

  // State, motion registers and registered phase decodes
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      y_q       <= YSTART10;
      vel       <= '0;
      playing_q <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state     <= state_n;
      y_q       <= y_n;
      vel       <= vel_n;
      playing_q <= (state_n == FLY);
      dead_q    <= (state_n == DEAD);
    end
  end

  assign bus.y          = y_q;
  assign bus.frame_tick = tick;
  assign bus.playing    = playing_q;
  assign bus.dead       = dead_q;
endmodule
